// File: rtl/pn_eval_multi.sv
// Polish-notation expression evaluator: buffers a token stream, evaluates it
// as postfix or prefix, and returns one result (single modes) or a sorted
// stream of results (multi modes).
module pn_eval_multi #(
  parameter int DATA_W  = 3,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32,
  parameter int CNT_W   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    operator,
  input  logic [DATA_W-1:0]       in,
  input  logic                    in_valid,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out,
  output logic                    err
);

  localparam int IDX_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_DATA,
    S_EVAL,
    S_SORT,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    M_POSTFIX,
    M_PREFIX,
    M_POSTFIX_MULTI,
    M_PREFIX_MULTI
  } mode_e;

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic                    tok_op_q  [MAX_LEN];
  logic                    tok_op_d  [MAX_LEN];
  logic [DATA_W-1:0]       tok_val_q [MAX_LEN];
  logic [DATA_W-1:0]       tok_val_d [MAX_LEN];
  logic signed [OUT_W-1:0] stk_q     [MAX_LEN];
  logic signed [OUT_W-1:0] stk_d     [MAX_LEN];
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        step_q, step_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        sp_q, sp_d;
  logic                    bad_q, bad_d;

  logic                    is_prefix, is_multi;
  logic                    eval_en, eval_last, err_now;
  logic [CNT_W-1:0]        rd_pos;
  logic [IDX_W-1:0]        rd_i, top_i, sec_i;
  logic signed [OUT_W-1:0] opa, opb, diff, res;

  assign is_prefix = mode_q[0];
  assign is_multi  = mode_q[1];

  // Operand fetch and ALU for the token currently being evaluated
  always_comb begin
    rd_pos = is_prefix ? (len_q - step_q - CNT_W'(1)) : step_q;
    rd_i   = rd_pos[IDX_W-1:0];
    top_i  = IDX_W'(sp_q - CNT_W'(1));
    sec_i  = IDX_W'(sp_q - CNT_W'(2));
    opa    = is_prefix ? stk_q[top_i] : stk_q[sec_i];
    opb    = is_prefix ? stk_q[sec_i] : stk_q[top_i];
    diff   = opa - opb;
    case (tok_val_q[rd_i][1:0])
      2'd0:    res = opa + opb;
      2'd1:    res = diff;
      2'd2:    res = opa * opb;
      default: res = diff[OUT_W-1] ? -diff : diff;
    endcase
    eval_en   = ((state_q == S_RD_DATA) && !in_valid) || (state_q == S_EVAL);
    eval_last = (step_q == len_q - CNT_W'(1));
    err_now   = bad_q || (is_multi ? (sp_q == '0) : (sp_q != CNT_W'(1)));
  end

  // Next-state, datapath updates and outputs
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tok_op_d  = tok_op_q;
    tok_val_d = tok_val_q;
    stk_d     = stk_q;
    len_d     = len_q;
    step_d    = step_q;
    idx_d     = idx_q;
    sp_d      = sp_q;
    bad_d     = bad_q;
    out_valid = 1'b0;
    out       = '0;
    err       = 1'b0;

    // The cycle that ends RD_DATA already evaluates the first token, so
    // evaluation occupies exactly L cycles starting at that cycle.
    if (eval_en) begin
      step_d = step_q + CNT_W'(1);
      if (!tok_op_q[rd_i]) begin
        if (sp_q == CNT_W'(MAX_LEN)) begin
          bad_d = 1'b1;
        end else begin
          stk_d[sp_q[IDX_W-1:0]] = OUT_W'(tok_val_q[rd_i]);
          sp_d = sp_q + CNT_W'(1);
        end
      end else if (sp_q < CNT_W'(2)) begin
        bad_d = 1'b1;
      end else begin
        stk_d[sec_i] = res;
        sp_d = sp_q - CNT_W'(1);
      end
      if (eval_last) begin
        idx_d   = '0;
        state_d = (is_multi && (sp_d != '0)) ? S_SORT : S_OUT;
      end else begin
        state_d = S_EVAL;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mode_d       = mode_e'(mode);
          tok_op_d[0]  = operator;
          tok_val_d[0] = in;
          len_d        = CNT_W'(1);
          step_d       = '0;
          idx_d        = '0;
          sp_d         = '0;
          bad_d        = 1'b0;
          state_d      = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (in_valid) begin
          if (len_q == CNT_W'(MAX_LEN)) begin
            bad_d = 1'b1;
          end else begin
            tok_op_d[len_q[IDX_W-1:0]]  = operator;
            tok_val_d[len_q[IDX_W-1:0]] = in;
            len_d = len_q + CNT_W'(1);
          end
        end
      end
      S_SORT: begin
        // One odd-even transposition phase; phase parity picks the pairs
        for (int unsigned i = 0; i + 1 < MAX_LEN; i++) begin
          if ((CNT_W'(i + 1) < sp_q) && (i[0] == idx_q[0])) begin
            if (is_prefix ? (stk_q[IDX_W'(i)] > stk_q[IDX_W'(i + 1)])
                          : (stk_q[IDX_W'(i)] < stk_q[IDX_W'(i + 1)])) begin
              stk_d[IDX_W'(i)]     = stk_q[IDX_W'(i + 1)];
              stk_d[IDX_W'(i + 1)] = stk_q[IDX_W'(i)];
            end
          end
        end
        if (idx_q == sp_q - CNT_W'(1)) begin
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (err_now) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          out = stk_q[idx_q[IDX_W-1:0]];
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == sp_q - CNT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= M_POSTFIX;
      tok_op_q  <= '{default: 1'b0};
      tok_val_q <= '{default: '0};
      stk_q     <= '{default: '0};
      len_q     <= '0;
      step_q    <= '0;
      idx_q     <= '0;
      sp_q      <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tok_op_q  <= tok_op_d;
      tok_val_q <= tok_val_d;
      stk_q     <= stk_d;
      len_q     <= len_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      sp_q      <= sp_d;
      bad_q     <= bad_d;
    end
  end

endmodule

// File: tb/tb_pn_eval_multi.sv
// Bench for pn_eval_multi: fixed vectors, reset corner cases, and random
// token streams checked against a stack/queue reference model.
module tb_pn_eval_multi;

  localparam int DATA_W  = 3;
  localparam int MAX_LEN = 16;
  localparam int OUT_W   = 32;
  localparam int CNT_W   = 5;
  localparam int NVEC    = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [1:0]              mode;
  logic                    operator;
  logic [DATA_W-1:0]       in;
  logic                    in_valid;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out;
  logic                    err;

  pn_eval_multi #(
    .DATA_W (DATA_W),
    .MAX_LEN(MAX_LEN),
    .OUT_W  (OUT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .operator (operator),
    .in       (in),
    .in_valid (in_valid),
    .out_valid(out_valid),
    .out      (out),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [159:0] toks;
    int           first;
    logic         err;
    int           nres;
    int           r0;
    int           r1;
    int           r2;
  } vec_t;

  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  int tk_op  [24];
  int tk_val [24];

  int                      got_cyc [$];
  logic signed [OUT_W-1:0] got_out [$];
  logic                    got_err [$];

  int   exp_res [$];
  int   exp_first;
  logic exp_err;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Tokens as characters: digits are operands, + - * | are operators 0..3
  task automatic load_vec(input logic [159:0] t, output int len);
    logic [7:0] ch;
    len = 0;
    for (int b = 0; b < 20; b++)
      if (t[8*b +: 8] != 8'h00) len = b + 1;
    for (int k = 0; k < len; k++) begin
      ch = t[8*(len-1-k) +: 8];
      case (ch)
        "+":     begin tk_op[k] = 1; tk_val[k] = 0; end
        "-":     begin tk_op[k] = 1; tk_val[k] = 1; end
        "*":     begin tk_op[k] = 1; tk_val[k] = 2; end
        "|":     begin tk_op[k] = 1; tk_val[k] = 3; end
        default: begin tk_op[k] = 0; tk_val[k] = int'(ch) - 48; end
      endcase
    end
  endtask

  // Starts and ends at a falling edge; offsets are relative to the cycle
  // in which in_valid first drops.
  task automatic drive_collect(input logic [1:0] m, input int len);
    bit done;
    got_cyc.delete();
    got_out.delete();
    got_err.delete();
    for (int k = 0; k < len; k++) begin
      mode     = m;
      in_valid = 1'b1;
      operator = tk_op[k][0];
      in       = tk_val[k][DATA_W-1:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    operator = 1'b0;
    in       = '0;
    done     = 1'b0;
    for (int c = 0; c < 4 * MAX_LEN + 16 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid === 1'b1) begin
        got_cyc.push_back(c);
        got_out.push_back(out);
        got_err.push_back(err);
      end else if (got_cyc.size() > 0) begin
        check("idle_out", out, 0);
        check("idle_err", err, 0);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: result burst did not end within the cycle budget");
    end
  endtask

  task automatic compare(input string name, input int first, input logic e,
                         input int res[$]);
    check({name, ".count"}, got_cyc.size(), res.size());
    for (int i = 0; i < got_cyc.size() && i < res.size(); i++) begin
      check($sformatf("%s.cyc%0d", name, i), got_cyc[i], first + i);
      check($sformatf("%s.out%0d", name, i), got_out[i], res[i]);
      check($sformatf("%s.err%0d", name, i), got_err[i], e);
    end
  endtask

  // Reference: evaluate with a queue as stack, then a stable insertion sort
  task automatic model(input logic [1:0] m, input int len);
    int q[$];
    int lx, a, b, t, s, r, key, j;
    bit bad, pre, multi;
    pre   = m[0];
    multi = m[1];
    lx    = (len > MAX_LEN) ? MAX_LEN : len;
    bad   = (len > MAX_LEN);
    for (int n = 0; n < lx; n++) begin
      int k;
      k = pre ? (lx - 1 - n) : n;
      if (tk_op[k] == 0) begin
        q.push_back(tk_val[k]);
      end else if (q.size() < 2) begin
        bad = 1'b1;
      end else begin
        t = q.pop_back();
        s = q.pop_back();
        a = pre ? t : s;
        b = pre ? s : t;
        case (tk_val[k] % 4)
          0:       r = a + b;
          1:       r = a - b;
          2:       r = a * b;
          default: r = (a - b < 0) ? (b - a) : (a - b);
        endcase
        q.push_back(r);
      end
    end
    exp_first = lx + (multi ? q.size() : 0);
    if (multi ? (q.size() == 0) : (q.size() != 1)) bad = 1'b1;
    exp_res.delete();
    if (bad) begin
      exp_err = 1'b1;
      exp_res.push_back(0);
    end else begin
      exp_err = 1'b0;
      if (multi) begin
        for (int i = 1; i < q.size(); i++) begin
          key = q[i];
          j   = i - 1;
          while (j >= 0 && (pre ? (key < q[j]) : (key > q[j]))) begin
            q[j+1] = q[j];
            j--;
          end
          q[j+1] = key;
        end
      end
      foreach (q[i]) exp_res.push_back(q[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         len, depth, cnt;
    int         er[$];
    logic [1:0] m;
    bit         seen;

    vecs[0]  = '{2'd0, "34+2*",            5,  1'b0, 1, 14, 0, 0};
    vecs[1]  = '{2'd1, "-*345",            5,  1'b0, 1, 7,  0, 0};
    vecs[2]  = '{2'd2, "23+716-",          10, 1'b0, 3, 7,  5, -5};
    vecs[3]  = '{2'd3, "+11*23",           8,  1'b0, 2, 2,  6, 0};
    vecs[4]  = '{2'd1, "|16",              3,  1'b0, 1, 5,  0, 0};
    vecs[5]  = '{2'd0, "3+",               2,  1'b1, 1, 0,  0, 0};
    vecs[6]  = '{2'd0, "12",               2,  1'b1, 1, 0,  0, 0};
    vecs[7]  = '{2'd0, "11111111111111111", 16, 1'b1, 1, 0,  0, 0};
    vecs[8]  = '{2'd0, "5",                1,  1'b0, 1, 5,  0, 0};
    vecs[9]  = '{2'd2, "1234567++++++77|", 18, 1'b0, 2, 28, 0, 0};
    vecs[10] = '{2'd2, "+",                1,  1'b1, 1, 0,  0, 0};
    vecs[11] = '{2'd0, "07-",              3,  1'b0, 1, -7, 0, 0};
    vecs[12] = '{2'd3, "2-13",             6,  1'b0, 2, -2, 2, 0};
    vecs[13] = '{2'd1, "-12",              3,  1'b0, 1, -1, 0, 0};
    vecs[14] = '{2'd0, "25|",              3,  1'b0, 1, 3,  0, 0};
    vecs[15] = '{2'd2, "+34",              5,  1'b1, 1, 0,  0, 0};

    reset    = 1'b1;
    mode     = 2'd0;
    operator = 1'b0;
    in       = '0;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset.out_valid", out_valid, 0);
    check("reset.out", out, 0);
    check("reset.err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fixed vectors, issued back to back with no idle gap
    for (int v = 0; v < NVEC; v++) begin
      load_vec(vecs[v].toks, len);
      drive_collect(vecs[v].mode, len);
      er.delete();
      er.push_back(vecs[v].r0);
      if (vecs[v].nres > 1) er.push_back(vecs[v].r1);
      if (vecs[v].nres > 2) er.push_back(vecs[v].r2);
      compare($sformatf("vec%0d", v), vecs[v].first, vecs[v].err, er);
    end

    // Reset asserted in the middle of EVAL
    load_vec("34+2*", len);
    for (int k = 0; k < len; k++) begin
      mode = 2'd0; in_valid = 1'b1; operator = tk_op[k][0]; in = tk_val[k][DATA_W-1:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_eval.out_valid", out_valid, 0);
    check("rst_eval.out", out, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) cnt++;
    end
    check("rst_eval.quiet", cnt, 0);
    load_vec(vecs[0].toks, len);
    drive_collect(2'd0, len);
    er.delete();
    er.push_back(14);
    compare("after_rst_eval", 5, 1'b0, er);

    // Reset asserted while a result is being presented
    load_vec("23+716-", len);
    for (int k = 0; k < len; k++) begin
      mode = 2'd2; in_valid = 1'b1; operator = tk_op[k][0]; in = tk_val[k][DATA_W-1:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("rst_out.seen", seen, 1);
    check("rst_out.first", out, 7);
    #1 reset = 1'b1;
    #1;
    check("rst_out.out_valid", out_valid, 0);
    check("rst_out.out", out, 0);
    check("rst_out.err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) cnt++;
    end
    check("rst_out.quiet", cnt, 0);

    // Random token streams against the reference model
    for (int r = 0; r < 80; r++) begin
      m = 2'($urandom % 4);
      if ($urandom % 10 == 0) len = MAX_LEN + 1 + int'($urandom % 2);
      else len = 1 + int'($urandom % MAX_LEN);
      depth = 0;
      for (int k = 0; k < len; k++) begin
        if ($urandom % 20 == 0) tk_op[k] = int'($urandom % 2);
        else if (depth >= 2 && $urandom % 5 < 2) tk_op[k] = 1;
        else tk_op[k] = 0;
        if (tk_op[k] != 0) begin
          tk_val[k] = int'($urandom % 4);
          if (depth > 0) depth--;
        end else begin
          tk_val[k] = int'($urandom % 8);
          depth++;
        end
      end
      drive_collect(m, len);
      model(m, len);
      compare($sformatf("rnd%0d", r), exp_first, exp_err, exp_res);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
